// File: rtl/execute_stage.sv
// execute_stage: EX stage of the pipelined MIPS datapath.
// Resolves EX/MEM and MEM/WB operand forwarding, computes the ALU result and
// the branch target, runs a shift-add multiplier behind a busy handshake and
// registers everything into an EX/MEM output register with bubble, stall and
// flush control.

module execute_stage #(
    parameter int WIDTH    = 32,  // datapath width, at least 8
    parameter int REG_BITS = 5,   // register-index width
    parameter bit MUL_EN   = 1'b1 // 1: funct 011000 multiplies, 0: it adds
) (
    input  logic                clk,
    input  logic                rst,
    // pipeline handshake
    input  logic                in_valid,
    input  logic                stall_in,
    input  logic                flush,
    // control carried through to later stages
    input  logic [1:0]          wb_ctl,
    input  logic [2:0]          m_ctl,       // {branch, memread, memwrite}
    input  logic                regdst,
    input  logic                alusrc,
    input  logic [1:0]          aluop,
    // ID/EX datapath
    input  logic [WIDTH-1:0]    npc,
    input  logic [WIDTH-1:0]    rdata1,
    input  logic [WIDTH-1:0]    rdata2,
    input  logic [WIDTH-1:0]    s_extend,
    input  logic [REG_BITS-1:0] rs,
    input  logic [REG_BITS-1:0] rt,
    input  logic [REG_BITS-1:0] rd,
    // forwarding sources
    input  logic                exmem_regwrite,
    input  logic                memwb_regwrite,
    input  logic [REG_BITS-1:0] exmem_rd,
    input  logic [REG_BITS-1:0] memwb_rd,
    input  logic [WIDTH-1:0]    exmem_value,
    input  logic [WIDTH-1:0]    memwb_value,
    // upstream hold request
    output logic                busy,
    // EX/MEM output register
    output logic                out_valid,
    output logic [1:0]          wb_ctlout,
    output logic                branch,
    output logic                memread,
    output logic                memwrite,
    output logic [WIDTH-1:0]    add_result,
    output logic                zero,
    output logic [WIDTH-1:0]    alu_result,
    output logic [WIDTH-1:0]    rdata2out,
    output logic [REG_BITS-1:0] dest_reg
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;

    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    fwd_b;
    logic [WIDTH-1:0]    op_b;
    logic [WIDTH-1:0]    alu_out;
    logic [WIDTH-1:0]    target;
    logic [REG_BITS-1:0] dest_sel;
    logic [5:0]          funct;
    logic                signed_lt;
    logic                is_mul;
    logic                accept;

    // multiplier working registers and the instruction held while it runs
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    mplier;
    logic [WIDTH-1:0]    acc;
    logic [1:0]          hold_wb;
    logic [2:0]          hold_m;
    logic [REG_BITS-1:0] hold_dest;
    logic [WIDTH-1:0]    hold_target;
    logic [WIDTH-1:0]    hold_rdata2;

    assign funct     = s_extend[5:0];
    assign op_b      = alusrc ? s_extend : fwd_b;
    assign signed_lt = $signed(op_a) < $signed(op_b);
    assign target    = npc + (s_extend << 2);
    assign dest_sel  = regdst ? rd : rt;

    // A multiply in flight or a stalled memory stage blocks new instructions.
    assign busy   = (state != S_IDLE) | stall_in;
    assign accept = in_valid & ~busy;

    // Operand forwarding: the younger EX/MEM result wins over MEM/WB; r0 never forwards.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        op_a  = rdata1;
        fwd_b = rdata2;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs)) begin
            op_a = exmem_value;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs)) begin
            op_a = memwb_value;
        end
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rt)) begin
            fwd_b = exmem_value;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rt)) begin
            fwd_b = memwb_value;
        end
    end

    // Single-cycle ALU; unknown functs fall back to add, and mult is flagged for the FSM.
    always_comb begin
        alu_out = op_a + op_b;
        is_mul  = 1'b0;
        case (aluop)
            ALU_ADD: alu_out = op_a + op_b;
            ALU_SUB: alu_out = op_a - op_b;
            ALU_SLT: alu_out = {{(WIDTH-1){1'b0}}, signed_lt};
            ALU_FN: begin
                case (funct)
                    FN_SUB:  alu_out = op_a - op_b;
                    FN_AND:  alu_out = op_a & op_b;
                    FN_OR:   alu_out = op_a | op_b;
                    FN_SLT:  alu_out = {{(WIDTH-1){1'b0}}, signed_lt};
                    FN_MULT: is_mul  = MUL_EN;
                    FN_ADD:  alu_out = op_a + op_b;
                    default: alu_out = op_a + op_b;
                endcase
            end
            default: alu_out = op_a + op_b;
        endcase
    end

    // Multiplier sequencer: IDLE -> MUL for WIDTH steps -> DONE until the output loads.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is only ever assigned with non-blocking assignments.
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_mul) begin
                        state <= S_MUL;
                        count <= CNT_W'(WIDTH);
                    end
                end
                S_MUL: begin
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!stall_in) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Shift-add datapath: freezes operands and control at accept, then adds one partial product per cycle.
    always_ff @(posedge clk) begin
        // NOTE: these registers need no reset; state decides when their contents are meaningful.
        if ((state == S_IDLE) && accept && is_mul) begin
            mcand       <= op_a;
            mplier      <= op_b;
            acc         <= '0;
            hold_wb     <= wb_ctl;
            hold_m      <= m_ctl;
            hold_dest   <= dest_sel;
            hold_target <= target;
            hold_rdata2 <= fwd_b;
        end else if (state == S_MUL) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // EX/MEM output register: flush beats stall, stall holds, otherwise load a result or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            wb_ctlout  <= '0;
            branch     <= 1'b0;
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            zero       <= 1'b0;
            alu_result <= '0;
            rdata2out  <= '0;
            add_result <= '0;
            dest_reg   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            wb_ctlout <= '0;
            branch    <= 1'b0;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
        end else if (stall_in) begin
            out_valid <= out_valid;
        end else if (state == S_DONE) begin
            out_valid                   <= 1'b1;
            wb_ctlout                   <= hold_wb;
            {branch, memread, memwrite} <= hold_m;
            alu_result                  <= acc;
            zero                        <= (acc == '0);
            rdata2out                   <= hold_rdata2;
            add_result                  <= hold_target;
            dest_reg                    <= hold_dest;
        end else if ((state == S_IDLE) && accept && !is_mul) begin
            out_valid                   <= 1'b1;
            wb_ctlout                   <= wb_ctl;
            {branch, memread, memwrite} <= m_ctl;
            alu_result                  <= alu_out;
            zero                        <= (alu_out == '0);
            rdata2out                   <= fwd_b;
            add_result                  <= target;
            dest_reg                    <= dest_sel;
        end else begin
            out_valid <= 1'b0;
            wb_ctlout <= '0;
            branch    <= 1'b0;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: scoreboard bench for execute_stage (WIDTH=32).
// The driver pushes the expected EX/MEM contents at every accept; an
// independent monitor compares each new output against the queue.

module tb_execute_stage;

    localparam int W = 32;
    localparam int R = 5;

    typedef struct {
        logic [1:0]   wb;
        logic [2:0]   m;
        logic         regdst;
        logic         alusrc;
        logic [1:0]   aluop;
        logic [W-1:0] npc;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic [W-1:0] imm;
        logic [R-1:0] rs;
        logic [R-1:0] rt;
        logic [R-1:0] rd;
        logic         exw;
        logic         mww;
        logic [R-1:0] exrd;
        logic [R-1:0] mwrd;
        logic [W-1:0] exv;
        logic [W-1:0] mwv;
    } stim_t;

    typedef struct {
        logic [W-1:0] alu;
        logic         zero;
        logic [W-1:0] addr;
        logic [W-1:0] rd2;
        logic [R-1:0] dest;
        logic [1:0]   wb;
        logic [2:0]   m;
        bit           is_mul;
        int           due;   // edge number of the output for single-cycle ops, -1 for mult
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, in_valid, stall_in, flush;
    logic [1:0]   wb_ctl;
    logic [2:0]   m_ctl;
    logic         regdst, alusrc;
    logic [1:0]   aluop;
    logic [W-1:0] npc, rdata1, rdata2, s_extend;
    logic [R-1:0] rs, rt, rd;
    logic         exmem_regwrite, memwb_regwrite;
    logic [R-1:0] exmem_rd, memwb_rd;
    logic [W-1:0] exmem_value, memwb_value;
    logic         busy, out_valid, branch, memread, memwrite, zero;
    logic [1:0]   wb_ctlout;
    logic [W-1:0] add_result, alu_result, rdata2out;
    logic [R-1:0] dest_reg;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mul_inflight = 1'b0;
    exp_t q[$];

    execute_stage #(.WIDTH(W), .REG_BITS(R), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall_in(stall_in), .flush(flush),
        .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc), .aluop(aluop),
        .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
        .rs(rs), .rt(rt), .rd(rd),
        .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_value(exmem_value), .memwb_value(memwb_value),
        .busy(busy), .out_valid(out_valid), .wb_ctlout(wb_ctlout),
        .branch(branch), .memread(memread), .memwrite(memwrite),
        .add_result(add_result), .zero(zero), .alu_result(alu_result),
        .rdata2out(rdata2out), .dest_reg(dest_reg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t e);
        check({tag, "_alu_result"}, alu_result, e.alu);
        check({tag, "_zero"},       zero, e.zero);
        check({tag, "_add_result"}, add_result, e.addr);
        check({tag, "_rdata2out"},  rdata2out, e.rd2);
        check({tag, "_dest_reg"},   dest_reg, e.dest);
        check({tag, "_wb_ctlout"},  wb_ctlout, e.wb);
        check({tag, "_m_ctl"},      {branch, memread, memwrite}, e.m);
    endtask

    // Reference model: forwarding priority, operand select and ALU function from the instruction set rules.
    function automatic exp_t model(input stim_t s);
        logic [W-1:0] a, bf, b;
        exp_t e;
        a  = s.r1;
        bf = s.r2;
        if (s.exw && s.exrd != 0 && s.exrd == s.rs)      a = s.exv;
        else if (s.mww && s.mwrd != 0 && s.mwrd == s.rs) a = s.mwv;
        if (s.exw && s.exrd != 0 && s.exrd == s.rt)      bf = s.exv;
        else if (s.mww && s.mwrd != 0 && s.mwrd == s.rt) bf = s.mwv;
        b = s.alusrc ? s.imm : bf;
        e.is_mul = 1'b0;
        case (s.aluop)
            2'd0: e.alu = a + b;
            2'd1: e.alu = a - b;
            2'd3: e.alu = {31'd0, $signed(a) < $signed(b)};
            default: begin
                case (s.imm[5:0])
                    6'd34:   e.alu = a - b;
                    6'd36:   e.alu = a & b;
                    6'd37:   e.alu = a | b;
                    6'd42:   e.alu = {31'd0, $signed(a) < $signed(b)};
                    6'd24: begin
                        e.alu    = a * b;
                        e.is_mul = 1'b1;
                    end
                    default: e.alu = a + b;
                endcase
            end
        endcase
        e.zero = (e.alu == 0);
        e.addr = s.npc + (s.imm << 2);
        e.rd2  = bf;
        e.dest = s.regdst ? s.rd : s.rt;
        e.wb   = s.wb;
        e.m    = s.m;
        e.due  = -1;
        return e;
    endfunction

    function automatic stim_t base();
        stim_t s;
        s.wb = 2'b10;  s.m = 3'b000; s.regdst = 1'b1; s.alusrc = 1'b0; s.aluop = 2'b00;
        s.npc = '0;    s.r1 = '0;    s.r2 = '0;       s.imm = '0;
        s.rs = 5'd1;   s.rt = 5'd2;  s.rd = 5'd3;
        s.exw = 1'b0;  s.mww = 1'b0; s.exrd = '0;     s.mwrd = '0;
        s.exv = '0;    s.mwv = '0;
        return s;
    endfunction

    function automatic logic [W-1:0] rval();
        case ($urandom_range(0, 3))
            0:       return W'($urandom_range(0, 15));
            1:       return 32'hFFFF_FFFF - W'($urandom_range(0, 15));
            2:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t        s;
        logic [5:0]   f;
        logic [W-1:0] tmp;
        case ($urandom_range(0, 6))
            0:       f = 6'd32;
            1:       f = 6'd34;
            2:       f = 6'd36;
            3:       f = 6'd37;
            4:       f = 6'd42;
            5:       f = 6'd24;
            default: f = 6'($urandom_range(0, 63));
        endcase
        tmp      = W'($urandom);
        s.wb     = 2'($urandom_range(0, 3));
        s.m      = 3'($urandom_range(0, 7));
        s.regdst = 1'($urandom_range(0, 1));
        s.aluop  = 2'($urandom_range(0, 3));
        s.alusrc = (s.aluop == 2'd2) ? 1'b0 : 1'($urandom_range(0, 1));
        s.imm    = (s.aluop == 2'd2) ? {tmp[W-1:6], f} : rval();
        s.npc    = W'($urandom);
        s.r1     = rval();
        s.r2     = rval();
        s.rs     = 5'($urandom_range(0, 7));
        s.rt     = 5'($urandom_range(0, 7));
        s.rd     = 5'($urandom_range(0, 31));
        s.exw    = 1'($urandom_range(0, 1));
        s.mww    = 1'($urandom_range(0, 1));
        s.exrd   = 5'($urandom_range(0, 7));
        s.mwrd   = 5'($urandom_range(0, 7));
        s.exv    = rval();
        s.mwv    = rval();
        return s;
    endfunction

    task automatic drive(input stim_t s);
        wb_ctl = s.wb;   m_ctl = s.m;   regdst = s.regdst; alusrc = s.alusrc; aluop = s.aluop;
        npc = s.npc;     rdata1 = s.r1; rdata2 = s.r2;     s_extend = s.imm;
        rs = s.rs;       rt = s.rt;     rd = s.rd;
        exmem_regwrite = s.exw; memwb_regwrite = s.mww;
        exmem_rd = s.exrd;      memwb_rd = s.mwrd;
        exmem_value = s.exv;    memwb_value = s.mwv;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input stim_t s);
        exp_t e;
        e = model(s);
        e.due = e.is_mul ? -1 : cyc + 1;
        q.push_back(e);
        if (e.is_mul) mul_inflight = 1'b1;
    endtask

    task automatic drop_mul();
        if (mul_inflight && q.size() > 0) void'(q.pop_back());
        mul_inflight = 1'b0;
    endtask

    // Present one instruction and wait (bounded) until the stage accepts it.
    task automatic issue(input stim_t s);
        bit ok;
        ok = 1'b0;
        drive(s);
        in_valid = 1'b1; stall_in = 1'b0; flush = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (!busy) begin
                push(s);
                ok = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        if (!ok) check("issue_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
    endtask

    // Monitor: sample just after each edge, while inputs still hold the values seen at that edge.
    initial begin : monitor
        exp_t e;
        exp_t last_exp;
        bit   last_valid;
        last_valid = 1'b0;
        last_exp   = model(base());
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last_valid = 1'b0;
            end else if (flush) begin
                check("flush_out_valid", out_valid, 0);
                check("flush_ctl", {wb_ctlout, branch, memread, memwrite}, 0);
                last_valid = 1'b0;
            end else if (stall_in) begin
                check("hold_out_valid", out_valid, last_valid);
                if (last_valid) cmp_out("hold", last_exp);
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    if (e.due >= 0) check("latency_edge", cyc, e.due);
                    cmp_out("out", e);
                    if (e.is_mul) mul_inflight = 1'b0;
                    last_exp   = e;
                    last_valid = 1'b1;
                end
            end else begin
                if (q.size() > 0 && q[0].due == cyc) check("on_time_out_valid", out_valid, 1);
                check("bubble_ctl", {wb_ctlout, branch, memread, memwrite}, 0);
                last_valid = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        stim_t s;
        int    n;
        rst = 1'b1; in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        drive(base());
        step();
        step();
        rst = 1'b0;

        // reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_ctl", {wb_ctlout, branch, memread, memwrite}, 0);
        check("rst_zero", zero, 0);
        check("rst_alu_result", alu_result, 0);
        check("rst_rdata2out", rdata2out, 0);
        check("rst_add_result", add_result, 0);
        check("rst_dest_reg", dest_reg, 0);
        check("rst_busy", busy, 0);

        // R-type add, one-cycle latency
        s = base(); s.aluop = 2'b10; s.imm = 32'd32; s.r1 = 32'd5; s.r2 = 32'd7; s.rd = 5'd3;
        issue(s);
        check("add_valid", out_valid, 1);
        check("add_result12", alu_result, 32'd12);
        check("add_zero", zero, 0);
        check("add_dest", dest_reg, 3);

        // forwarding: EX/MEM beats MEM/WB
        s = base(); s.rs = 5'd4; s.exw = 1'b1; s.exrd = 5'd4; s.exv = 32'd100;
        s.mww = 1'b1; s.mwrd = 5'd4; s.mwv = 32'd9; s.r1 = 32'd1; s.alusrc = 1'b1; s.imm = 32'd1;
        issue(s);
        check("fwd_exmem", alu_result, 32'd101);
        s.rs = 5'd0;
        issue(s);
        check("fwd_r0", alu_result, 32'd2);

        // multiply 6 x 7: busy immediately, output exactly 33 edges after accept
        s = base(); s.aluop = 2'b10; s.imm = 32'd24; s.r1 = 32'd6; s.r2 = 32'd7;
        issue(s);
        check("mul_busy", busy, 1);
        wait_valid(n);
        check("mul_latency", n, 33);
        check("mul_42", alu_result, 32'd42);

        s.r1 = 32'hFFFF_FFFF; s.r2 = 32'd2;
        issue(s);
        wait_valid(n);
        check("mul_wrap", alu_result, 32'hFFFF_FFFE);

        // stall for 3 cycles in DONE
        s.r1 = 32'd3; s.r2 = 32'd5;
        issue(s);
        for (int i = 0; i < 32; i++) step();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("done_stall_valid", out_valid, 0);
        end
        stall_in = 1'b0;
        step();
        check("done_release_valid", out_valid, 1);
        check("done_release_15", alu_result, 32'd15);

        // stall during a single-cycle op holds the previous output
        s = base(); s.r1 = 32'd40; s.r2 = 32'd2;
        issue(s);
        stall_in = 1'b1; in_valid = 1'b1;
        drive(rand_stim());
        step();
        step();
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_42", alu_result, 32'd42);
        in_valid = 1'b0; stall_in = 1'b0;
        step();

        // flush mid-multiply, then a normal add
        s = base(); s.aluop = 2'b10; s.imm = 32'd24; s.r1 = 32'd9; s.r2 = 32'd9;
        issue(s);
        for (int i = 0; i < 5; i++) step();
        flush = 1'b1;
        drop_mul();
        step();
        flush = 1'b0;
        #1;
        check("flush_mul_valid", out_valid, 0);
        check("flush_mul_busy", busy, 0);
        s = base(); s.r1 = 32'd11; s.r2 = 32'd22;
        issue(s);
        check("after_flush_add", alu_result, 32'd33);

        // flush together with stall gives a bubble
        stall_in = 1'b1; flush = 1'b1;
        step();
        check("flush_stall_valid", out_valid, 0);
        stall_in = 1'b0; flush = 1'b0;

        // branch target and zero flag
        s = base(); s.aluop = 2'b01; s.r1 = 32'd9; s.r2 = 32'd9; s.npc = 32'h100; s.imm = 32'd4;
        s.m = 3'b100;
        issue(s);
        check("br_zero", zero, 1);
        check("br_target", add_result, 32'h110);
        check("br_branch", branch, 1);

        // signed slt
        s = base(); s.aluop = 2'b11; s.r1 = 32'hFFFF_FFFF; s.r2 = 32'd1;
        issue(s);
        check("slt_neg", alu_result, 32'd1);

        // reset mid-multiply emits nothing
        s = base(); s.aluop = 2'b10; s.imm = 32'd24; s.r1 = 32'd5; s.r2 = 32'd5;
        issue(s);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        drop_mul();
        step();
        rst = 1'b0;
        check("rst_mul_valid", out_valid, 0);
        check("rst_mul_busy", busy, 0);
        for (int i = 0; i < 40; i++) step();

        // randomized traffic with stalls and occasional flushes
        for (int i = 0; i < 1500; i++) begin
            s = rand_stim();
            drive(s);
            in_valid = ($urandom_range(0, 3) != 0);
            stall_in = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            #1;
            if (in_valid && !busy && !flush) push(s);
            if (flush) drop_mul();
            step();
        end

        // drain
        in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        for (int i = 0; i < 100 && q.size() > 0; i++) step();
        step();
        check("drain_queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
